// File: rtl/packet_bit_timer_pkg.sv
// Shared types and constants for the packet bit timer: state encoding and the
// minimum usable bit period.
package packet_bit_timer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRST  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        WAIT   = 3'd5
    } bit_timer_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FIRST  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/packet_bit_timer_if.sv
// Configuration, control and strobe bundle between the start-bit detector,
// the timer and the receive shift register; state is exposed for debug.
interface packet_bit_timer_if import packet_bit_timer_pkg::*; #(
    parameter int CNT_BITS  = 14,
    parameter int SIZE_BITS = 4
) ();
    // Level interface, no handshake: enable_timer is held high for a whole
    // frame, each *_strobe / packet_done is a single-cycle registered pulse.
    logic                 enable_timer;
    logic [CNT_BITS-1:0]  bit_period;
    logic [SIZE_BITS-1:0] data_size;
    logic                 parity_en;
    logic [1:0]           stop_bits;
    logic                 sample_mid;
    logic                 shift_strobe;
    logic                 parity_strobe;
    logic                 stop_strobe;
    logic                 packet_done;
    logic [SIZE_BITS-1:0] bit_index;
    logic                 busy;
    bit_timer_state_t     state;

    modport master (
        output enable_timer, bit_period, data_size, parity_en, stop_bits, sample_mid,
        input  shift_strobe, parity_strobe, stop_strobe, packet_done, bit_index, busy, state
    );

    modport slave (
        input  enable_timer, bit_period, data_size, parity_en, stop_bits, sample_mid,
        output shift_strobe, parity_strobe, stop_strobe, packet_done, bit_index, busy, state
    );
endinterface

// File: rtl/packet_bit_timer_flex_counter.sv
// Flexible cycle counter: counts 0..rollover_val-1 while enabled and flags the
// last cycle of each phase so the owner can register a strobe on that edge.
module packet_bit_timer_flex_counter #(
    parameter int NUM_CNT_BITS = 15
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear_i,
    input  logic                    count_enable_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic                    rollover_flag_o
);
    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        rollover_flag_o = count_enable_i &&
                          (count_q == rollover_val_i - NUM_CNT_BITS'(1));
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (rollover_flag_o)
            count_d = '0;
        else if (count_enable_i)
            count_d = count_q + NUM_CNT_BITS'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/packet_bit_timer.sv
// Frame bit timer: from a start-bit trigger, emits data, parity and stop
// sample strobes at a latched bit period, with optional mid-bit offset.
module packet_bit_timer import packet_bit_timer_pkg::*; #(
    parameter int CNT_BITS  = 14,
    parameter int SIZE_BITS = 4,
    parameter int MAX_DATA  = 9,
    parameter int MAX_STOP  = 2
) (
    input  logic               clk,
    input  logic               n_rst,
    packet_bit_timer_if.slave  tif
);
    localparam logic [SIZE_BITS-1:0] ONE_S = SIZE_BITS'(1);

    logic [2:0]           state_q, state_d;
    logic [CNT_BITS-1:0]  period_q, period_d, period_s;
    logic [CNT_BITS:0]    first_len_q, first_len_d, first_len_s, phase_len;
    logic [SIZE_BITS-1:0] dsize_q, dsize_d, dsize_s;
    logic [SIZE_BITS-1:0] bit_idx_q, bit_idx_d;
    logic [1:0]           nstop_q, nstop_d, nstop_s;
    logic [1:0]           stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 shift_q, shift_d, parity_q, parity_d;
    logic                 stop_q, stop_d, done_q, done_d, busy_q, busy_d;
    logic                 active, cnt_clear, cnt_flag;
    logic [2:0]           after_data;

    always_comb begin
        period_s = (tif.bit_period < CNT_BITS'(MIN_PERIOD)) ? CNT_BITS'(MIN_PERIOD)
                                                             : tif.bit_period;
        first_len_s = {1'b0, period_s} +
                      (tif.sample_mid ? {2'b00, period_s[CNT_BITS-1:1]} : '0);
        if (tif.data_size == '0)                         dsize_s = ONE_S;
        else if (tif.data_size > SIZE_BITS'(MAX_DATA))   dsize_s = SIZE_BITS'(MAX_DATA);
        else                                             dsize_s = tif.data_size;
        if (tif.stop_bits == 2'd0)                       nstop_s = 2'd1;
        else if (tif.stop_bits > 2'(MAX_STOP))           nstop_s = 2'(MAX_STOP);
        else                                             nstop_s = tif.stop_bits;
    end

    // The cycle counter only runs while a frame is live; dropping enable clears it
    // on the same edge the FSM aborts, so a coincident strobe is suppressed.
    assign active    = state_q inside {ST_FIRST, ST_DATA, ST_PARITY, ST_STOP};
    assign cnt_clear = !active || !tif.enable_timer;
    assign phase_len = (state_q == ST_FIRST) ? first_len_q : {1'b0, period_q};

    packet_bit_timer_flex_counter #(.NUM_CNT_BITS(CNT_BITS + 1)) u_cycle_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (cnt_clear),
        .count_enable_i  (active),
        .rollover_val_i  (phase_len),
        .rollover_flag_o (cnt_flag)
    );

    assign after_data = par_q ? ST_PARITY : ST_STOP;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        first_len_d = first_len_q;
        dsize_d     = dsize_q;
        nstop_d     = nstop_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        shift_d     = 1'b0;
        parity_d    = 1'b0;
        stop_d      = 1'b0;
        done_d      = 1'b0;
        if (active && !tif.enable_timer) begin
            state_d    = ST_IDLE;
            bit_idx_d  = '0;
            stop_cnt_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_idx_d  = '0;
                    stop_cnt_d = 2'd0;
                    if (tif.enable_timer) begin
                        state_d     = ST_FIRST;
                        period_d    = period_s;
                        first_len_d = first_len_s;
                        dsize_d     = dsize_s;
                        nstop_d     = nstop_s;
                        par_d       = tif.parity_en;
                    end
                end
                ST_FIRST: if (cnt_flag) begin
                    shift_d   = 1'b1;
                    bit_idx_d = '0;
                    state_d   = (dsize_q == ONE_S) ? after_data : ST_DATA;
                end
                ST_DATA: if (cnt_flag) begin
                    shift_d   = 1'b1;
                    bit_idx_d = bit_idx_q + ONE_S;
                    if (bit_idx_q + ONE_S == dsize_q - ONE_S) state_d = after_data;
                end
                ST_PARITY: if (cnt_flag) begin
                    parity_d = 1'b1;
                    state_d  = ST_STOP;
                end
                ST_STOP: if (cnt_flag) begin
                    stop_d = 1'b1;
                    if (stop_cnt_q + 2'd1 == nstop_q) begin
                        done_d     = 1'b1;
                        stop_cnt_d = 2'd0;
                        state_d    = ST_WAIT;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end
                end
                ST_WAIT: if (!tif.enable_timer) begin
                    state_d   = ST_IDLE;
                    bit_idx_d = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            first_len_q <= '0;
            dsize_q     <= '0;
            nstop_q     <= 2'd0;
            par_q       <= 1'b0;
            bit_idx_q   <= '0;
            stop_cnt_q  <= 2'd0;
            shift_q     <= 1'b0;
            parity_q    <= 1'b0;
            stop_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            first_len_q <= first_len_d;
            dsize_q     <= dsize_d;
            nstop_q     <= nstop_d;
            par_q       <= par_d;
            bit_idx_q   <= bit_idx_d;
            stop_cnt_q  <= stop_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            stop_q      <= stop_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign tif.shift_strobe  = shift_q;
    assign tif.parity_strobe = parity_q;
    assign tif.stop_strobe   = stop_q;
    assign tif.packet_done   = done_q;
    assign tif.bit_index     = bit_idx_q;
    assign tif.busy          = busy_q;
    assign tif.state         = bit_timer_state_t'(state_q);
endmodule

// File: tb/tb_packet_bit_timer.sv
// Directed bench for packet_bit_timer: table of frame configurations with
// hand-computed timing, plus abort, abort-on-strobe and async reset sequences.
module tb_packet_bit_timer;
    import packet_bit_timer_pkg::*;

    typedef struct {
        logic [13:0] bp;
        logic [3:0]  ds;
        logic        par;
        logic [1:0]  sb;
        logic        mid;
        int          per;    // effective period
        int          first;  // cycles from E0 to first shift
        int          ns;     // shift strobes
        int          nst;    // stop strobes
    } vec_t;

    logic clk;
    logic n_rst;
    int   total;
    int   bad;
    vec_t vecs[7];

    packet_bit_timer_if #(.CNT_BITS(14), .SIZE_BITS(4)) tif ();

    packet_bit_timer #(.CNT_BITS(14), .SIZE_BITS(4), .MAX_DATA(9), .MAX_STOP(2)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .tif   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_pulses(vec_t v, int t);
        int k;
        int k2;
        if (t < v.first || ((t - v.first) % v.per) != 0) return 4'b0000;
        k = (t - v.first) / v.per;
        if (k < v.ns) return 4'b1000;
        if (v.par && k == v.ns) return 4'b0100;
        k2 = k - v.ns - (v.par ? 1 : 0);
        if (k2 < v.nst) return (k2 == v.nst - 1) ? 4'b0011 : 4'b0010;
        return 4'b0000;
    endfunction

    function automatic int last_time(vec_t v);
        return v.first + (v.ns + (v.par ? 1 : 0) + v.nst - 1) * v.per;
    endfunction

    function automatic logic [3:0] act_pulses();
        return {tif.shift_strobe, tif.parity_strobe, tif.stop_strobe, tif.packet_done};
    endfunction

    // Drives the config and enable at a falling edge; returns #1 after E0 with
    // the config inputs scrambled to prove they were latched.
    task automatic start_frame(vec_t v);
        @(negedge clk);
        tif.bit_period   = v.bp;
        tif.data_size    = v.ds;
        tif.parity_en    = v.par;
        tif.stop_bits    = v.sb;
        tif.sample_mid   = v.mid;
        tif.enable_timer = 1'b1;
        @(posedge clk);
        #1;
        tif.bit_period = 14'($urandom_range(0, 16383));
        tif.data_size  = 4'($urandom_range(0, 15));
        tif.parity_en  = ~v.par;
        tif.stop_bits  = 2'($urandom_range(0, 3));
        tif.sample_mid = ~v.mid;
    endtask

    task automatic check_cycle(vec_t v, int t);
        logic [3:0] e;
        e = exp_pulses(v, t);
        check("pulses", 32'(act_pulses()), 32'(e));
        check("busy", 32'(tif.busy), 32'd1);
        if (e[3]) check("bit_index", 32'(tif.bit_index), 32'((t - v.first) / v.per));
    endtask

    task automatic check_idle(string name);
        check({name, "_pulses"}, 32'(act_pulses()), 32'd0);
        check({name, "_busy"}, 32'(tif.busy), 32'd0);
        check({name, "_idx"}, 32'(tif.bit_index), 32'd0);
    endtask

    task automatic run_frame(vec_t v);
        start_frame(v);
        check_cycle(v, 0);
        for (int t = 1; t <= last_time(v) + 6; t++) begin
            @(posedge clk);
            #1;
            check_cycle(v, t);
        end
        @(negedge clk);
        tif.enable_timer = 1'b0;
        @(posedge clk);
        #1;
        check_idle("release");
    endtask

    task automatic abort_at(vec_t v, int t_drop);
        start_frame(v);
        check_cycle(v, 0);
        for (int t = 1; t <= t_drop; t++) begin
            @(posedge clk);
            #1;
            check_cycle(v, t);
        end
        tif.enable_timer = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check_idle("abort");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{14'd10, 4'd8,  1'b0, 2'd1, 1'b0, 10, 10, 8, 1};
        vecs[1] = '{14'd10, 4'd8,  1'b0, 2'd1, 1'b1, 10, 15, 8, 1};
        vecs[2] = '{14'd4,  4'd7,  1'b1, 2'd2, 1'b0,  4,  4, 7, 2};
        vecs[3] = '{14'd0,  4'd0,  1'b0, 2'd3, 1'b0,  2,  2, 1, 2};
        vecs[4] = '{14'd3,  4'd15, 1'b1, 2'd0, 1'b1,  3,  4, 9, 1};
        vecs[5] = '{14'd1,  4'd9,  1'b0, 2'd2, 1'b1,  2,  3, 9, 2};
        vecs[6] = '{14'd5,  4'd1,  1'b1, 2'd1, 1'b1,  5,  7, 1, 1};

        n_rst            = 1'b0;
        tif.enable_timer = 1'b0;
        tif.bit_period   = '0;
        tif.data_size    = '0;
        tif.parity_en    = 1'b0;
        tif.stop_bits    = 2'd0;
        tif.sample_mid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("post_reset");

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Abort after the third shift, then a fresh frame must restart timing.
        abort_at(vecs[0], 30);
        run_frame(vecs[0]);

        // Abort on the same edge a shift would have fired.
        abort_at(vecs[0], 39);

        // Async reset in the middle of the data phase.
        start_frame(vecs[2]);
        for (int t = 1; t <= 10; t++) begin
            @(posedge clk);
            #1;
            check_cycle(vecs[2], t);
        end
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_idle("async_rst");
        tif.enable_timer = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_idle("rst_idle");
        end
        run_frame(vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
